// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type, clock/audio rate constants and interpolation reciprocal helper
package audio_pkg;
  typedef logic signed [15:0] sample_t;
  localparam int CLK_HZ = 100_000_000;
  localparam int AUDIO_HZ = 48_000;
  function automatic logic signed [23:0] recip(input int cps);
    return 24'((1 << 24) / cps);
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample FIFO with registered occupancy and no push-to-pop bypass
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and data (ignored when full)
//   pop, dout     read request (ignored when empty) and head-of-queue data
//   level         registered occupancy 0..DEPTH
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sample_t                  din,
  input  logic                     pop,
  output sample_t                  dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  sample_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign push_ok = push && level != LW'(DEPTH);
  assign pop_ok = pop && level != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + AW'(1) : rd_ptr;
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end
endmodule

// File: rtl/audio_sample_interp.sv
// audio_sample_interp: paces queued audio samples at the sample rate and interpolates between them for the DAC
//   clk, rst                 clock, synchronous active-high reset
//   in_sample/in_valid/in_ready   sample push handshake into the FIFO
//   sample_out               registered interpolated (or held) sample
//   sample_tick, underrun    registered one-cycle period-start and empty-FIFO pulses
//   fifo_level               FIFO occupancy
//   INTERP_LINEAR_EN defined: linear interpolation; undefined: zero-order hold
module audio_sample_interp
  import audio_pkg::*;
#(
  parameter int CLK_PER_SAMPLE = CLK_HZ / AUDIO_HZ,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  sample_t                       in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output sample_t                       sample_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(CLK_PER_SAMPLE);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [PW-1:0] phase;
  logic tick, pop, empty;
  sample_t head, target, next_out;
  assign tick = phase == PW'(CLK_PER_SAMPLE - 1);
  assign empty = fifo_level == '0;
  assign pop = tick && !empty;
  assign in_ready = fifo_level != LW'(FIFO_DEPTH);
  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .din   (in_sample),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      target <= '0;
      sample_tick <= 1'b0;
      underrun <= 1'b0;
      sample_out <= '0;
    end else begin
      phase <= tick ? '0 : phase + PW'(1);
      target <= pop ? head : target;
      sample_tick <= tick;
      underrun <= tick && empty;
      sample_out <= next_out;
    end
  end
`ifdef INTERP_LINEAR_EN
  localparam logic signed [23:0] RECIP = recip(CLK_PER_SAMPLE);
  sample_t base;
  logic signed [16:0] diff;
  logic signed [40:0] step;
  logic signed [41:0] acc;
  logic signed [17:0] sum;
  // new target is the FIFO head, new base is the outgoing target
  assign diff = $signed({head[15], head}) - $signed({target[15], target});
  // acc holds a 24-bit fraction; the integer part is bounded by |diff| so 18 bits suffice
  assign sum = $signed({{2{base[15]}}, base}) + $signed(acc[41:24]);
  assign next_out = sum > 18'sd32767 ? 16'sh7fff : sum < -18'sd32768 ? 16'sh8000 : sum[15:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      step <= '0;
      acc <= '0;
    end else begin
      base <= tick ? target : base;
      step <= tick ? (pop ? 41'(diff) * 41'(RECIP) : '0) : step;
      acc <= tick ? '0 : acc + 42'(step);
    end
  end
`else
  assign next_out = target;
`endif
endmodule

// File: tb/tb_audio_sample_interp.sv
// tb_audio_sample_interp: directed self-checking bench for audio_sample_interp with CLK_PER_SAMPLE = 8
module tb_audio_sample_interp;
  import audio_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, sample_tick, underrun;
  sample_t in_sample = '0;
  sample_t sample_out;
  logic [2:0] fifo_level;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
`ifdef INTERP_LINEAR_EN
  int ramp_exp [9] = '{0, 100, 200, 300, 400, 500, 600, 700, 800};
  int up_exp [9] = '{800, 825, 850, 875, 900, 925, 950, 975, 1000};
  int sat_exp [9] = '{32767, 24575, 16383, 8191, -1, -8193, -16385, -24577, -32768};
`else
  int ramp_exp [9] = '{default: 800};
  int up_exp [9] = '{default: 1000};
  int sat_exp [9] = '{default: -32768};
`endif
  int fill_exp [9] = '{1, 2, 3, 4, 4, 4, 4, 3, 4};

  always #5 clk = ~clk;

  audio_sample_interp #(.CLK_PER_SAMPLE(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sample_out  (sample_out),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input sample_t v);
    in_sample = v;
    in_valid = 1'b1;
    step_clk;
    in_valid = 1'b0;
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step_clk;
      cnt++;
    end while (!sample_tick && cnt < 20);
    if (!sample_tick) cnt = -1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    step_clk;
    step_clk;
    chk("rst_out", $signed(sample_out), 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
  endtask

  initial begin
    do_reset;
    push(16'sd0);
    push(16'sd800);
    chk("ramp_level2", fifo_level, 2);
    wait_tick(n);
    chk("first_tick_delay", n, 6);
    chk("first_pop_level", fifo_level, 1);
    chk("first_pop_underrun", underrun, 0);
    wait_tick(n);
    chk("tick_period", n, 8);
    chk("second_pop_level", fifo_level, 0);
    for (int m = 1; m <= 9; m++) begin
      step_clk;
      chk($sformatf("ramp_out_%0d", m), $signed(sample_out), ramp_exp[m-1]);
      chk($sformatf("ramp_tick_%0d", m), sample_tick, m == 8);
      chk($sformatf("ramp_underrun_%0d", m), underrun, m == 8);
    end
    push(16'sd1000);
    wait_tick(n);
    chk("up_tick_delay", n, 6);
    chk("up_underrun", underrun, 0);
    for (int m = 1; m <= 9; m++) begin
      step_clk;
      chk($sformatf("up_out_%0d", m), $signed(sample_out), up_exp[m-1]);
      chk($sformatf("up_underrun_%0d", m), underrun, m == 8);
    end
    wait_tick(n);
    chk("hold_tick_delay", n, 7);
    chk("hold_underrun", underrun, 1);
    chk("hold_out", $signed(sample_out), 1000);
    step_clk;
    chk("hold_underrun_pulse", underrun, 0);
    chk("hold_out_after", $signed(sample_out), 1000);

    do_reset;
    in_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      in_sample = sample_t'(c * 10);
      step_clk;
      chk($sformatf("fill_level_%0d", c), fifo_level, fill_exp[c-1]);
      chk($sformatf("fill_ready_%0d", c), in_ready, fill_exp[c-1] != 4);
      chk($sformatf("fill_tick_%0d", c), sample_tick, c == 8);
    end
    in_valid = 1'b0;

    do_reset;
    push(16'sd32767);
    push(-16'sd32768);
    wait_tick(n);
    chk("sat_tick1", n, 6);
    wait_tick(n);
    chk("sat_tick2", n, 8);
    for (int m = 1; m <= 9; m++) begin
      step_clk;
      chk($sformatf("sat_out_%0d", m), $signed(sample_out), sat_exp[m-1]);
    end
    push(16'sd11);
    push(16'sd22);
    chk("mid_level_before", fifo_level, 2);
    chk("mid_out_before", $signed(sample_out), -32768);
    rst = 1'b1;
    step_clk;
    rst = 1'b0;
    chk("mid_out", $signed(sample_out), 0);
    chk("mid_level", fifo_level, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_tick", sample_tick, 0);
    wait_tick(n);
    chk("mid_tick_delay", n, 8);
    chk("mid_underrun", underrun, 1);
    chk("mid_out_after", $signed(sample_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
